bounce_emulator: RTL and testbench

BOUNCE_EMULATOR -- requirements
Module: bounce_emulator

---
 rtl/bounce_pkg.sv | 23 ++
 rtl/lfsr16.sv | 23 ++
 rtl/bounce_emulator.sv | 116 +++++++++++
 tb/tb_bounce_emulator.sv | 251 +++++++++++++++++++++++++
 4 files changed

// File: rtl/bounce_pkg.sv
// Shared types and constants for the contact-bounce emulator: FSM states and
// the 16-bit Galois LFSR that drives the chatter.
package bounce_pkg;

    typedef enum logic {
        IDLE   = 1'b0,
        BOUNCE = 1'b1
    } state_t;

    localparam int          LFSR_W       = 16;
    localparam logic [15:0] LFSR_TAPS    = 16'hB400;
    localparam logic [15:0] DEFAULT_SEED = 16'hACE1;

    function automatic logic [LFSR_W-1:0] lfsr_next(input logic [LFSR_W-1:0] s);
        return (s >> 1) ^ (s[0] ? LFSR_TAPS : '0);
    endfunction

    // An all-zero seed would lock the LFSR at zero forever.
    function automatic logic [LFSR_W-1:0] fix_seed(input logic [LFSR_W-1:0] s);
        return (s == '0) ? DEFAULT_SEED : s;
    endfunction

endpackage

// File: rtl/lfsr16.sv
// Free-running 16-bit Galois LFSR (right shift, taps 16'hB400); maximal length,
// so it cycles through all 65535 non-zero values and never reaches zero.
module lfsr16
    import bounce_pkg::*;
#(
    parameter logic [15:0] SEED = DEFAULT_SEED
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    output logic [15:0] o_state
);

    localparam logic [15:0] RST_VAL = fix_seed(SEED);

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            o_state <= RST_VAL;
        end else begin
            o_state <= lfsr_next(o_state);
        end
    end

endmodule

// File: rtl/bounce_emulator.sv
// Turns a clean level into a bouncy contact signal: after each clean edge the
// output chatters (LFSR-driven) for BOUNCE_CYCLES clocks, then settles.
module bounce_emulator
    import bounce_pkg::*;
#(
    parameter int          BOUNCE_CYCLES = 16,
    parameter logic [15:0] LFSR_SEED     = DEFAULT_SEED
) (
    input  logic                             i_clk,
    input  logic                             i_rst_n,
    input  logic                             i_clean,
    input  logic                             i_enable,
    output logic                             o_bouncy,
    output logic                             o_busy,
    output logic                             o_dbg_state,
    output logic [$clog2(BOUNCE_CYCLES)-1:0] o_dbg_count,
    output logic [15:0]                      o_dbg_lfsr
);

    localparam int            CW   = $clog2(BOUNCE_CYCLES);
    localparam logic [CW-1:0] LAST = CW'(BOUNCE_CYCLES - 1);

    state_t        state, state_n;
    logic          r_clean;
    logic          r_target, target_n;
    logic [CW-1:0] count, count_n;
    logic          bouncy_n;
    logic          busy_n;
    logic [15:0]   lfsr;

    lfsr16 #(
        .SEED(LFSR_SEED)
    ) u_lfsr (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .o_state (lfsr)
    );

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_n;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_clean  <= 1'b0;
            r_target <= 1'b0;
            count    <= '0;
            o_bouncy <= 1'b0;
            o_busy   <= 1'b0;
        end else begin
            r_clean  <= i_clean;
            r_target <= target_n;
            count    <= count_n;
            o_bouncy <= bouncy_n;
            o_busy   <= busy_n;
        end
    end

    always_comb begin
        state_n  = state;
        target_n = r_target;
        count_n  = count;
        bouncy_n = o_bouncy;
        busy_n   = o_busy;
        if (!i_enable) begin
            // Transparent mode: follow the registered level, abort any window.
            state_n  = IDLE;
            busy_n   = 1'b0;
            target_n = r_clean;
            bouncy_n = r_clean;
            count_n  = '0;
        end else begin
            case (state)
                IDLE: begin
                    bouncy_n = r_target;
                    if (r_clean != r_target) begin
                        target_n = r_clean;
                        count_n  = '0;
                        state_n  = BOUNCE;
                        busy_n   = 1'b1;
                    end
                end
                BOUNCE: begin
                    if (lfsr[0]) begin
                        bouncy_n = ~o_bouncy;
                    end
                    // A new clean edge mid-window takes priority and restarts it.
                    if (r_clean != r_target) begin
                        target_n = r_clean;
                        count_n  = '0;
                    end else if (count == LAST) begin
                        bouncy_n = r_target;
                        state_n  = IDLE;
                        busy_n   = 1'b0;
                        count_n  = '0;
                    end else begin
                        count_n = count + 1'b1;
                    end
                end
                default: begin
                    state_n = IDLE;
                    busy_n  = 1'b0;
                end
            endcase
        end
    end

    assign o_dbg_state = state;
    assign o_dbg_count = count;
    assign o_dbg_lfsr  = lfsr;

endmodule

// File: tb/tb_bounce_emulator.sv
// Directed bench for bounce_emulator: window timing, restart, transparent mode,
// async reset, LFSR period with zero seed, and a downstream debounce filter.
module tb_bounce_emulator;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        rst2_n;
    logic        clean;
    logic        enable;
    logic        clean2;
    logic        enable2;
    logic        bouncy, busy, dbg_state;
    logic [2:0]  dbg_count;
    logic [15:0] dbg_lfsr;
    logic        bouncy2, busy2, dbg_state2;
    logic [3:0]  dbg_count2;
    logic [15:0] dbg_lfsr2;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    bounce_emulator #(
        .BOUNCE_CYCLES (8),
        .LFSR_SEED     (16'hACE1)
    ) dut (
        .i_clk       (clk),
        .i_rst_n     (rst_n),
        .i_clean     (clean),
        .i_enable    (enable),
        .o_bouncy    (bouncy),
        .o_busy      (busy),
        .o_dbg_state (dbg_state),
        .o_dbg_count (dbg_count),
        .o_dbg_lfsr  (dbg_lfsr)
    );

    bounce_emulator #(
        .BOUNCE_CYCLES (16),
        .LFSR_SEED     (16'h0000)
    ) dut_zero_seed (
        .i_clk       (clk),
        .i_rst_n     (rst2_n),
        .i_clean     (clean2),
        .i_enable    (enable2),
        .o_bouncy    (bouncy2),
        .o_busy      (busy2),
        .o_dbg_state (dbg_state2),
        .o_dbg_count (dbg_count2),
        .o_dbg_lfsr  (dbg_lfsr2)
    );

    // Reference LFSR for predicting chatter.
    logic [15:0] m_lfsr;
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) m_lfsr <= 16'hACE1;
        else        m_lfsr <= {1'b0, m_lfsr[15:1]} ^ (m_lfsr[0] ? 16'hB400 : 16'h0000);
    end

    // Downstream debounce filter, DEBOUNCE_LIMIT = 20.
    logic flt_on = 1'b0;
    logic flt_q;
    int   flt_cnt;
    int   flt_trans;
    always @(posedge clk) begin
        if (!flt_on) begin
            flt_q     <= bouncy;
            flt_cnt   <= 0;
            flt_trans <= 0;
        end else if (bouncy != flt_q) begin
            if (flt_cnt == 19) begin
                flt_q     <= bouncy;
                flt_cnt   <= 0;
                flt_trans <= flt_trans + 1;
            end else begin
                flt_cnt <= flt_cnt + 1;
            end
        end else begin
            flt_cnt <= 0;
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic run_directed();
        logic       exp_b;
        logic       pre;
        logic       prev_b;
        logic       saw_toggle;
        logic       hist[$];

        // Reset values
        rst_n  = 1'b0;
        clean  = 1'b0;
        enable = 1'b1;
        #12;
        check("rst_bouncy", bouncy, 0);
        check("rst_busy", busy, 0);
        check("rst_lfsr", dbg_lfsr, 16'hACE1);
        check("rst_count", dbg_count, 0);
        check("rst_state", dbg_state, 0);
        @(negedge clk);
        rst_n = 1'b1;
        step();
        check("rel_idle_busy", busy, 0);
        check("rel_idle_bouncy", bouncy, 0);
        check("lfsr_step1", dbg_lfsr, 16'hE270);
        step();
        check("lfsr_step2", dbg_lfsr, 16'h7138);

        // Single isolated rising edge, BOUNCE_CYCLES = 8
        clean      = 1'b1;
        exp_b      = 1'b0;
        prev_b     = 1'b0;
        saw_toggle = 1'b0;
        for (int k = 1; k <= 12; k++) begin
            pre = m_lfsr[0];
            step();
            if (k >= 3 && k <= 9 && pre) exp_b = ~exp_b;
            if (k == 10) exp_b = 1'b1;
            if (k >= 3 && k <= 9 && bouncy != prev_b) saw_toggle = 1'b1;
            prev_b = bouncy;
            check($sformatf("win_bouncy_k%0d", k), bouncy, exp_b);
            check($sformatf("win_busy_k%0d", k), busy, (k >= 2 && k <= 9) ? 1 : 0);
            if (k >= 2 && k <= 9) check($sformatf("win_count_k%0d", k), dbg_count, k - 2);
        end
        check("win_toggled", saw_toggle, 1);
        check("lfsr_vs_model", dbg_lfsr, m_lfsr);

        // Re-toggle mid-window restarts the window
        enable = 1'b0;
        clean  = 1'b0;
        repeat (3) step();
        check("pre_restart_bouncy", bouncy, 0);
        enable = 1'b1;
        step();
        clean = 1'b1;
        for (int k = 1; k <= 6; k++) begin
            step();
            check($sformatf("rs_busy_k%0d", k), busy, (k >= 2) ? 1 : 0);
        end
        check("rs_count_at4", dbg_count, 4);
        clean = 1'b0;
        for (int j = 1; j <= 12; j++) begin
            step();
            check($sformatf("rs_busy_j%0d", j), busy, (j <= 9) ? 1 : 0);
            if (j == 1) check("rs_count_j1", dbg_count, 5);
            if (j >= 2 && j <= 9) check($sformatf("rs_count_j%0d", j), dbg_count, j - 2);
            if (j >= 10) check($sformatf("rs_bouncy_j%0d", j), bouncy, 0);
        end

        // Transparent mode: o_bouncy is i_clean delayed by two clocks
        enable = 1'b0;
        clean  = 1'b0;
        repeat (3) step();
        hist.push_back(1'b0);
        for (int n = 0; n < 24; n++) begin
            clean = ((n / 3) % 2 == 1);
            hist.push_back(clean);
            step();
            check($sformatf("thru_bouncy_n%0d", n), bouncy, hist[n]);
            check($sformatf("thru_busy_n%0d", n), busy, 0);
        end
        enable = 1'b1;
        step();
        step();
        check("thru_end_bouncy", bouncy, 1);

        // Asynchronous reset in the middle of a window
        clean = 1'b0;
        repeat (4) step();
        check("ar_busy_before", busy, 1);
        #2;
        rst_n = 1'b0;
        #1;
        check("ar_bouncy", bouncy, 0);
        check("ar_busy", busy, 0);
        check("ar_lfsr", dbg_lfsr, 16'hACE1);
        check("ar_count", dbg_count, 0);
        check("ar_state", dbg_state, 0);
        @(negedge clk);
        rst_n = 1'b1;
        step();
        check("ar_first_busy", busy, 0);
        check("ar_first_state", dbg_state, 0);
        check("ar_first_lfsr", dbg_lfsr, 16'hE270);

        // Debounce filter sees exactly one transition per clean edge
        step();
        flt_on = 1'b1;
        step();
        for (int e = 0; e < 4; e++) begin
            clean = ~clean;
            repeat (40) step();
            check($sformatf("flt_trans_e%0d", e), flt_trans, e + 1);
            check($sformatf("flt_level_e%0d", e), flt_q, clean);
        end
        flt_on = 1'b0;
    endtask

    task automatic run_period();
        int zeros;
        int first_hit;
        zeros     = 0;
        first_hit = 0;
        rst2_n    = 1'b0;
        clean2    = 1'b0;
        enable2   = 1'b0;
        #7;
        check("zs_rst_lfsr", dbg_lfsr2, 16'hACE1);
        @(negedge clk);
        rst2_n = 1'b1;
        for (int i = 1; i <= 70000; i++) begin
            step();
            if (dbg_lfsr2 == 16'h0000) zeros++;
            if (first_hit == 0 && dbg_lfsr2 == 16'hACE1) first_hit = i;
            if (i == 1) check("zs_step1", dbg_lfsr2, 16'hE270);
        end
        check("zs_never_zero", zeros, 0);
        check("zs_period", first_hit, 65535);
        check("zs_busy_idle", busy2, 0);
    endtask

    initial begin
        rst_n   = 1'b0;
        rst2_n  = 1'b0;
        clean   = 1'b0;
        enable  = 1'b0;
        clean2  = 1'b0;
        enable2 = 1'b0;
        fork
            run_directed();
            run_period();
        join
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
